// File: rtl/restador_sumador_multiciclo_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder/subtractor.
package restador_sumador_multiciclo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic OP_SUMA  = 1'b0;
  localparam logic OP_RESTA = 1'b1;

  function automatic int calc_nsl(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice index width; a single-slice configuration still needs one bit.
  function automatic int calc_idx_w(input int width, input int slice);
    int nsl;
    nsl = width / slice;
    return (nsl <= 1) ? 1 : $clog2(nsl);
  endfunction

endpackage

// File: rtl/restador_sumador_multiciclo_if.sv
// Start/busy/done bus between the operand registers and the adder/subtractor.
interface restador_sumador_multiciclo_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] R;
  logic             Carry;
  logic             Borrow;
  logic             Ovf;
  logic             Zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B,
    input  R, Carry, Borrow, Ovf, Zero, busy, done
  );

  modport slave (
    input  start, op, A, B,
    output R, Carry, Borrow, Ovf, Zero, busy, done
  );
endinterface

// File: rtl/restador_sumador_multiciclo_sumador_slice.sv
// SLICE-bit ripple-carry adder, reused every cycle by the multi-cycle top.
module sumador_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/restador_sumador_multiciclo.sv
// Multi-cycle two's-complement adder/subtractor: one SLICE-bit slice per clock,
// registered result and Carry/Borrow/Ovf/Zero flags, start/busy/done handshake.
module restador_sumador_multiciclo
  import restador_sumador_multiciclo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic clk,
  input  logic rst_n,
  restador_sumador_multiciclo_if.slave bus
);

  localparam int NSL   = calc_nsl(WIDTH, SLICE);
  localparam int IDX_W = calc_idx_w(WIDTH, SLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NSL-1:0][SLICE-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic                      op_q, op_d, cy_q, cy_d;
  logic                      carry_q, carry_d, borrow_q, borrow_d;
  logic                      ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE-1:0]          sum_s;
  logic                      cout_s;

  // Operands are held slice-addressable so one adder can walk them by idx.
  sumador_slice #(.SLICE(SLICE)) u_slice (
    .a   (a_q[idx_q]),
    .b   (b_q[idx_q]),
    .cin (cy_q),
    .s   (sum_s),
    .cout(cout_s)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cy_d     = cy_q;
    r_d      = r_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = (bus.op == OP_RESTA) ? ~bus.B : bus.B;
          op_d    = bus.op;
          cy_d    = bus.op;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d[idx_q] = sum_s;
        cy_d       = cout_s;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          idx_d    = '0;
          carry_d  = cout_s;
          borrow_d = op_q & ~cout_s;
          ovf_d    = (a_q[NSL-1][SLICE-1] == b_q[NSL-1][SLICE-1]) &&
                     (r_d[NSL-1][SLICE-1] != a_q[NSL-1][SLICE-1]);
          zero_d   = (r_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= 1'b0;
      cy_q     <= 1'b0;
      r_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      cy_q     <= cy_d;
      r_q      <= r_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.R      = r_q;
  assign bus.Carry  = carry_q;
  assign bus.Borrow = borrow_q;
  assign bus.Ovf    = ovf_q;
  assign bus.Zero   = zero_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_restador_sumador_multiciclo.sv
// Scoreboard bench: directed cases on WIDTH=16/SLICE=4, random sweeps on 8/8 and 32/8.
module tb_restador_sumador_multiciclo;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;   // {Carry, Borrow, Ovf, Zero}
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  restador_sumador_multiciclo_if #(.WIDTH(16)) bus16 ();
  restador_sumador_multiciclo_if #(.WIDTH(8))  bus8 ();
  restador_sumador_multiciclo_if #(.WIDTH(32)) bus32 ();

  restador_sumador_multiciclo #(.WIDTH(16), .SLICE(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  restador_sumador_multiciclo #(.WIDTH(8),  .SLICE(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  restador_sumador_multiciclo #(.WIDTH(32), .SLICE(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic o);
    logic [63:0] mask, beff, sum;
    logic        carry, ovf;
    exp_t        e;
    mask  = (64'd1 << w) - 64'd1;
    beff  = (o ? ~{32'd0, b} : {32'd0, b}) & mask;
    sum   = {32'd0, a} + beff + {63'd0, o};
    e.r   = 32'(sum & mask);
    carry = sum[w];
    ovf   = (a[w-1] == beff[w-1]) && (e.r[w-1] != a[w-1]);
    e.f   = {carry, o & ~carry, ovf, (e.r == 32'd0)};
    return e;
  endfunction

  // Result monitors: pop the oldest expectation whenever a done pulse is seen.
  always @(negedge clk) begin
    exp_t e;
    if (bus16.done) begin
      if (q16.size() == 0) chk("sb16_unexpected_done", 1, 0);
      else begin
        e = q16.pop_front();
        chk("R16", bus16.R, e.r);
        chk("flags16", {bus16.Carry, bus16.Borrow, bus16.Ovf, bus16.Zero}, e.f);
      end
    end
    if (bus8.done) begin
      if (q8.size() == 0) chk("sb8_unexpected_done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("R8", bus8.R, e.r);
        chk("flags8", {bus8.Carry, bus8.Borrow, bus8.Ovf, bus8.Zero}, e.f);
      end
    end
    if (bus32.done) begin
      if (q32.size() == 0) chk("sb32_unexpected_done", 1, 0);
      else begin
        e = q32.pop_front();
        chk("R32", bus32.R, e.r);
        chk("flags32", {bus32.Carry, bus32.Borrow, bus32.Ovf, bus32.Zero}, e.f);
      end
    end
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic o,
                      input logic [15:0] er, input logic [3:0] ef, input bit poke);
    int n, busy_n, dn;
    @(negedge clk);
    bus16.A = a; bus16.B = b; bus16.op = o; bus16.start = 1'b1;
    q16.push_back('{r: {16'd0, er}, f: ef});
    @(posedge clk); #1;
    bus16.start = 1'b0;
    n = 0; busy_n = 0;
    do begin
      @(negedge clk); n++;
      if (bus16.busy) busy_n++;
      if (poke && n == 2) begin
        bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.op = 1'b1; bus16.start = 1'b1;
      end
      if (poke && n == 3) bus16.start = 1'b0;
    end while (!bus16.done && n < 20);
    chk("latency16", n - 1, 4);
    chk("busy_cycles16", busy_n, 4);
    @(negedge clk);
    chk("done_width16", bus16.done, 0);
    chk("hold_R16", bus16.R, er);
    if (poke) begin
      dn = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus16.done) dn++;
      end
      chk("start_in_run_ignored", dn, 0);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic o);
    int n;
    @(negedge clk);
    bus8.A = a; bus8.B = b; bus8.op = o; bus8.start = 1'b1;
    q8.push_back(model(8, {24'd0, a}, {24'd0, b}, o));
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus8.done && n < 20);
    chk("latency8", n - 1, 1);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic o);
    int n;
    @(negedge clk);
    bus32.A = a; bus32.B = b; bus32.op = o; bus32.start = 1'b1;
    q32.push_back(model(32, a, b, o));
    @(posedge clk); #1;
    bus32.start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus32.done && n < 20);
    chk("latency32", n - 1, 4);
  endtask

  initial begin
    int n, dn, t1, t2;
    bus16.start = 0; bus16.op = 0; bus16.A = '0; bus16.B = '0;
    bus8.start  = 0; bus8.op  = 0; bus8.A  = '0; bus8.B  = '0;
    bus32.start = 0; bus32.op = 0; bus32.A = '0; bus32.B = '0;
    repeat (3) @(negedge clk);
    chk("reset_R16", bus16.R, 0);
    chk("reset_ctl16", {bus16.Carry, bus16.Borrow, bus16.Ovf, bus16.Zero, bus16.busy, bus16.done}, 0);
    chk("reset_R8", bus8.R, 0);
    chk("reset_R32", bus32.R, 0);
    rst_n = 1'b1;

    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0010, 0);
    op16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b0100, 0);
    op16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1010, 0);
    op16(16'h1234, 16'h1234, 1'b1, 16'h0000, 4'b1001, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001, 0);
    op16(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 4'b0000, 1);

    // start held high: second operation accepted in the IDLE cycle after done.
    @(negedge clk);
    bus16.A = 16'h0100; bus16.B = 16'h0001; bus16.op = 1'b1; bus16.start = 1'b1;
    q16.push_back('{r: 32'h00FF, f: 4'b1000});
    @(posedge clk); #1;
    bus16.A = 16'h4000; bus16.B = 16'h4000; bus16.op = 1'b0;
    q16.push_back('{r: 32'h8000, f: 4'b0010});
    n = 0;
    do begin @(negedge clk); n++; end while (!bus16.done && n < 20);
    t1 = cyc;
    @(posedge clk); @(posedge clk); #1;
    bus16.start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus16.done && n < 20);
    t2 = cyc;
    chk("b2b_period", t2 - t1, 6);
    @(negedge clk);

    // Asynchronous reset in the second RUN cycle aborts without a done pulse.
    bus16.A = 16'h1111; bus16.B = 16'h2222; bus16.op = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_abort_busy", bus16.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_R16", bus16.R, 0);
    chk("abort_ctl16", {bus16.Carry, bus16.Borrow, bus16.Ovf, bus16.Zero, bus16.busy, bus16.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus16.done) dn++;
    end
    chk("abort_no_done", dn, 0);
    op16(16'h0003, 16'h0004, 1'b0, 16'h0007, 4'b0000, 0);

    // Corner operands first, then random sweeps.
    op8(8'h7F, 8'h01, 1'b0);
    op8(8'h80, 8'h01, 1'b1);
    op8(8'h00, 8'h00, 1'b1);
    op32(32'h7FFF_FFFF, 32'h1, 1'b0);
    op32(32'hFFFF_FFFF, 32'h1, 1'b0);
    op32(32'h8000_0000, 32'h1, 1'b1);
    for (int i = 0; i < 1000; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1000; i++)
      op32($urandom, $urandom, 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    chk("sb16_drained", q16.size(), 0);
    chk("sb8_drained", q8.size(), 0);
    chk("sb32_drained", q32.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/restador_sumador_multiciclo.md
Name: restador_sumador_multiciclo

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor that replaces the fixed 8-bit combinational subtractor.
- Processes a WIDTH-bit operation in WIDTH/SLICE clock cycles, SLICE bits per cycle.
- Uses a start/busy/done handshake.
- Registers the result and the Carry, Borrow, Ovf and Zero flags.
- Sits between the operand registers and the datapath/display logic of the lab ALU.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥ 2 and a multiple of SLICE.
SLICE, 4, bits processed per cycle; SLICE = WIDTH gives single-cycle operation.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = A+B, 1 = A−B.
A  input  WIDTH  minuend/addend, captured on the accepted start.
B  input  WIDTH  subtrahend/addend, captured on the accepted start.
R  output  WIDTH  result, registered.
Carry  output  1  carry out of the MSB of A + B_eff + cin.
Borrow  output  1  op=1: ~Carry; op=0: 0.
Ovf  output  1  two's-complement overflow.
Zero  output  1  R == 0.
busy  output  1  high while the operation is in progress.
done  output  1  one-cycle pulse when R and the flags become valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE, slice index = 0.
  - R = 0, Carry = Borrow = Ovf = Zero = 0, busy = done = 0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Definitions:
  - NSL = WIDTH/SLICE.
  - B_eff = op ? ~B : B.
  - cin = op.
- IDLE:
  - On start=1 at the clock edge: latch A, B_eff, op; set carry register = cin; idx = 0; go to RUN; busy=1 from the next cycle.
- RUN, one slice per edge:
  - R[idx*SLICE +: SLICE] = A slice + B_eff slice + carry register.
  - Carry register <= slice carry out; idx <= idx+1.
  - On the edge that processes slice NSL−1, go to DONE.
- DONE, lasts exactly one cycle:
  - done=1, busy=0, flags valid.
  - Next edge returns to IDLE with done=0.
- Latency: start sampled at edge k → done high in the cycle after edge k+NSL.
  - WIDTH=16, SLICE=4: done visible 4 cycles after the start edge.
- Flags are registered on the final-slice edge:
  - Carry = carry out of the MSB.
  - Borrow = op & ~Carry.
  - Ovf = (A[MSB] == B_eff[MSB]) & (R[MSB] != A[MSB]).
  - Zero = (full R == 0).
- Hold behaviour:
  - R and the flags hold their values from DONE through IDLE until the next accepted start.
  - During RUN, R shows partial results; R and the flags are undefined for consumers until done.
- start handling:
  - start is ignored in RUN and DONE; no queuing.
  - start held high continuously: the next operation is accepted in the IDLE cycle after DONE (back-to-back period = NSL+2 cycles).
- Changes on A, B or op after acceptance have no effect on the operation in progress.
- Wrap-around: results are modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Op constants: OP_SUMA=1'b0, OP_RESTA=1'b1.
  - A function computing NSL and the index width, clog2(NSL), minimum 1.
- One natural sub-module: sumador_slice, a SLICE-bit ripple adder.
  - Inputs: a, b, cin. Outputs: s, cout.
  - Instantiated once and reused each cycle by muxing the slices.

Test Plan (WIDTH=16, SLICE=4 unless stated):
- Add 0x7FFF+0x0001 → R=0x8000, Ovf=1, Carry=0, Borrow=0, Zero=0; done exactly 4 cycles after the start edge, 1 cycle wide; busy high for 4 cycles.
- Sub 0x0005−0x0007 → R=0xFFFE, Carry=0, Borrow=1, Ovf=0, Zero=0. Sub 0x8000−0x0001 → R=0x7FFF, Ovf=1, Borrow=0.
- Sub 0x1234−0x1234 → R=0x0000, Zero=1, Carry=1, Borrow=0. Add 0xFFFF+0x0001 → R=0, Carry=1, Zero=1, Ovf=0.
- Pulse start again during RUN with different operands → ignored; the first result completes unchanged. Hold start high → second op accepted in the IDLE cycle after done; period = 6 cycles.
- Assert rst_n=0 in the second RUN cycle → all outputs 0 immediately (asynchronous); no done pulse. After release, a fresh add 0x0003+0x0004 → R=0x0007.
- Parameter sweep with WIDTH=8/SLICE=8 (done 1 cycle after the start edge) and WIDTH=32/SLICE=8: 1000 random A, B, op per configuration, compared against a reference model of A±B mod 2^WIDTH and all four flags.
